recon_desc_arb: RTL and testbench
=================================

RECON_DESC_ARB -- requirements
Module: recon_desc_arb

Interface
REQ-001 SHALL have parameter PORTS, 2, number of descriptor requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, 34, DMA address width.
REQ-003 SHALL have parameter DMA_DESC_LEN_WIDTH, 20, descriptor length width.
REQ-004 SHALL have parameter DMA_DESC_TAG_WIDTH, 8, requester tag width.
REQ-005 SHALL have parameter MAX_OUTSTANDING, 4, in-flight descriptors allowed per port.
REQ-006 SHALL have derived constants CL_PORTS = max(1, clog2(PORTS)) and M_TAG_WIDTH = DMA_DESC_TAG_WIDTH + CL_PORTS.
REQ-007 SHALL have clk  input  1  single clock; all logic on its rising edge.
REQ-008 SHALL have rst  input  1  synchronous, active-high reset.
REQ-009 SHALL have s_axis_desc_addr  input  PORTS*ADDR_WIDTH  per-port descriptor address.
REQ-010 SHALL have s_axis_desc_len  input  PORTS*DMA_DESC_LEN_WIDTH  per-port length in bytes.
REQ-011 SHALL have s_axis_desc_tag  input  PORTS*DMA_DESC_TAG_WIDTH  per-port tag.
REQ-012 SHALL have s_axis_desc_valid  input  PORTS  per-port request valid.
REQ-013 SHALL have s_axis_desc_ready  output  PORTS  per-port accept.
REQ-014 SHALL have m_axis_desc_addr / _len / _tag  output  ADDR_WIDTH / DMA_DESC_LEN_WIDTH / M_TAG_WIDTH  descriptor to DMA engine.
REQ-015 SHALL have m_axis_desc_valid  output  1 and m_axis_desc_ready  input  1  DMA descriptor handshake.
REQ-016 SHALL have s_axis_desc_status_tag  input  M_TAG_WIDTH, s_axis_desc_status_error  input  4, s_axis_desc_status_valid  input  1  DMA completion.
REQ-017 SHALL have m_axis_desc_status_tag  output  DMA_DESC_TAG_WIDTH, m_axis_desc_status_error  output  4, m_axis_desc_status_valid  output  PORTS  routed completion.
REQ-018 SHALL have outstanding  output  PORTS*clog2(MAX_OUTSTANDING+1)  per-port in-flight count.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, ZLEN_RESP.
REQ-020 In IDLE, eligible ports SHALL be those with valid=1 and outstanding<MAX_OUTSTANDING; the grant SHALL be round-robin starting at the port after the last grant (port 0 after reset).
REQ-021 On grant, s_axis_desc_ready[p] SHALL pulse for exactly that cycle (combinational, one port only); the descriptor SHALL be captured.
REQ-022 A captured descriptor with len!=0 SHALL enter ISSUE; m_axis_desc_valid SHALL rise next cycle with addr, len and tag = {p, tag}; fields SHALL be held stable until m_axis_desc_ready=1, then return to IDLE.
REQ-023 Sustained throughput SHALL be one descriptor per 2 cycles when m_axis_desc_ready is held 1.
REQ-024 outstanding[p] SHALL increment on the cycle the descriptor is accepted by the DMA, not on grant.
REQ-025 A captured descriptor with len==0 SHALL NOT be forwarded; enter ZLEN_RESP; emit local status (valid[p], tag, error 4'hE) on the first cycle with s_axis_desc_status_valid=0, then IDLE.
REQ-026 DMA status SHALL be routed registered, 1-cycle latency: valid[p]=1 for p = tag[M_TAG_WIDTH-1 -: CL_PORTS], tag = low DMA_DESC_TAG_WIDTH bits, error passed unchanged, outstanding[p] decremented.
REQ-027 Status with port index >= PORTS SHALL be dropped, no counter change.
REQ-028 Decrement at 0 SHALL saturate at 0; increment and decrement of the same port in one cycle SHALL leave it unchanged.
REQ-029 m_axis_desc_status_valid SHALL be one-hot or zero every cycle; DMA status SHALL always take priority over local status.

Reset
REQ-030 While rst=1: FSM=IDLE, RR pointer=port 0, outstanding=0, m_axis_desc_valid=0, m_axis_desc_status_valid=0, s_axis_desc_ready=0, data outputs=0.
REQ-031 rst mid-ISSUE or mid-ZLEN_RESP SHALL abandon the descriptor with no status generated.

Structure
REQ-032 FSM encodings and error code ZLEN_ERR=4'hE SHALL live in shared package recon_pkg.
REQ-033 Round-robin grant logic SHALL be sub-module recon_rr_arb (request mask in, one-hot grant out, pointer update on accept).

Verification
REQ-034 Port0 and port1 both valid, len=0x100, tags 0x11/0x22, ready=1 -> DMA tags {0,0x11} then {1,0x22}, 2 cycles apart.
REQ-035 Port0 issues 4 descriptors, no status -> port0 ready stays 0, outstanding[0]=4; one status tag {0,x} -> outstanding[0]=3, port0 regranted.
REQ-036 Port1 len=0, tag 0x5A, DMA status to port0 same cycle -> port0 status first, port1 gets tag 0x5A error 0xE next cycle; DMA valid never rises.
REQ-037 m_axis_desc_ready low 10 cycles -> addr/len/tag stable, outstanding unchanged until handshake.
REQ-038 Status tag {0,0x33} in the same cycle as a port0 DMA accept -> outstanding[0] unchanged, status valid[0] with tag 0x33.
REQ-039 rst asserted during ISSUE -> next cycle all valids 0, outstanding 0, next grant starts at port 0.

Source files
------------

// File: rtl/recon_pkg.sv
// ---------------------------------------------------------------------------
// recon_pkg
// Shared definitions for the descriptor arbiter: the FSM state encoding, the
// error code reported for zero-length descriptors, and a helper that sizes
// the port-index field that is prepended to requester tags.
// ---------------------------------------------------------------------------
package recon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_ZLEN_RESP = 2'd2
   } state_t;

   localparam logic [3:0] ZLEN_ERR = 4'hE;

   // Width of the port-index field; a single-port build still carries one
   // bit so the prepended tag field never collapses to zero width.
   function automatic int clPorts(input int ports);
      int c;
      c = $clog2(ports);
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/recon_desc_arb_if.sv
// ---------------------------------------------------------------------------
// recon_desc_arb_if
// Bundles every bus signal of the descriptor arbiter: the per-port request
// streams, the single descriptor stream to the DMA engine, the DMA
// completion stream, the per-port routed completions and the per-port
// in-flight counters.
// Modports:
//   master - the arbiter side (accepts requests, drives the DMA, routes status)
//   slave  - the environment side (requesters, DMA engine, completion sinks)
// ---------------------------------------------------------------------------
interface recon_desc_arb_if
   import recon_pkg::*;
#(
   parameter int PORTS              = 2,
   parameter int ADDR_WIDTH         = 34,
   parameter int DMA_DESC_LEN_WIDTH = 20,
   parameter int DMA_DESC_TAG_WIDTH = 8,
   parameter int MAX_OUTSTANDING    = 4
);
   localparam int CL_PORTS    = clPorts(PORTS);
   localparam int M_TAG_WIDTH = DMA_DESC_TAG_WIDTH + CL_PORTS;
   localparam int CNT_WIDTH   = $clog2(MAX_OUTSTANDING + 1);

   logic [PORTS*ADDR_WIDTH-1:0]         s_axis_desc_addr;
   logic [PORTS*DMA_DESC_LEN_WIDTH-1:0] s_axis_desc_len;
   logic [PORTS*DMA_DESC_TAG_WIDTH-1:0] s_axis_desc_tag;
   logic [PORTS-1:0]                    s_axis_desc_valid;
   logic [PORTS-1:0]                    s_axis_desc_ready;

   logic [ADDR_WIDTH-1:0]               m_axis_desc_addr;
   logic [DMA_DESC_LEN_WIDTH-1:0]       m_axis_desc_len;
   logic [M_TAG_WIDTH-1:0]              m_axis_desc_tag;
   logic                                m_axis_desc_valid;
   logic                                m_axis_desc_ready;

   logic [M_TAG_WIDTH-1:0]              s_axis_desc_status_tag;
   logic [3:0]                          s_axis_desc_status_error;
   logic                                s_axis_desc_status_valid;

   logic [DMA_DESC_TAG_WIDTH-1:0]       m_axis_desc_status_tag;
   logic [3:0]                          m_axis_desc_status_error;
   logic [PORTS-1:0]                    m_axis_desc_status_valid;

   logic [PORTS*CNT_WIDTH-1:0]          outstanding;

   modport master (
      input  s_axis_desc_addr, s_axis_desc_len, s_axis_desc_tag, s_axis_desc_valid,
      output s_axis_desc_ready,
      output m_axis_desc_addr, m_axis_desc_len, m_axis_desc_tag, m_axis_desc_valid,
      input  m_axis_desc_ready,
      input  s_axis_desc_status_tag, s_axis_desc_status_error, s_axis_desc_status_valid,
      output m_axis_desc_status_tag, m_axis_desc_status_error, m_axis_desc_status_valid,
      output outstanding
   );

   modport slave (
      output s_axis_desc_addr, s_axis_desc_len, s_axis_desc_tag, s_axis_desc_valid,
      input  s_axis_desc_ready,
      input  m_axis_desc_addr, m_axis_desc_len, m_axis_desc_tag, m_axis_desc_valid,
      output m_axis_desc_ready,
      output s_axis_desc_status_tag, s_axis_desc_status_error, s_axis_desc_status_valid,
      input  m_axis_desc_status_tag, m_axis_desc_status_error, m_axis_desc_status_valid,
      input  outstanding
   );

endinterface

// File: rtl/recon_rr_arb.sv
// ---------------------------------------------------------------------------
// recon_rr_arb
// Round-robin grant over a request mask. The search starts at the port after
// the most recently accepted grant (port 0 after reset).
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   i_req        - request mask, one bit per port
//   i_accept     - the current grant was taken; advance the pointer
//   o_grant      - one-hot grant (all zero when nothing requests)
//   o_grantIdx   - binary index of the granted port
//   o_anyGrant   - some port is granted this cycle
// ---------------------------------------------------------------------------
module recon_rr_arb #(
   parameter int PORTS    = 2,
   parameter int CL_PORTS = 1
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [PORTS-1:0]    i_req,
   input  logic                i_accept,
   output logic [PORTS-1:0]    o_grant,
   output logic [CL_PORTS-1:0] o_grantIdx,
   output logic                o_anyGrant
);
   logic [CL_PORTS-1:0] r_ptr;
   logic [CL_PORTS-1:0] w_ptrNext;
   int                  w_idx;

   // Walk the ports starting at the pointer and take the first requester.
   // The pointer for the next search is the port just after this winner.
   always_comb begin
      o_grant    = '0;
      o_grantIdx = '0;
      o_anyGrant = 1'b0;
      w_idx      = 0;
      for (int k = 0; k < PORTS; k++) begin
         w_idx = (int'(r_ptr) + k) % PORTS;
         if (!o_anyGrant && i_req[w_idx]) begin
            o_anyGrant     = 1'b1;
            o_grant[w_idx] = 1'b1;
            o_grantIdx     = CL_PORTS'(w_idx);
         end
      end
      w_ptrNext = (int'(o_grantIdx) == PORTS - 1) ? '0 : o_grantIdx + CL_PORTS'(1);
   end

   // The pointer moves only when the grant is actually taken, so a port that
   // is granted but not accepted keeps its priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (i_accept && o_anyGrant) begin
         r_ptr <= w_ptrNext;
      end
   end

endmodule

// File: rtl/recon_desc_arb.sv
// ---------------------------------------------------------------------------
// recon_desc_arb
// Arbitrates descriptor requests from PORTS requesters onto one DMA
// descriptor stream, tracks in-flight descriptors per port, and routes DMA
// completions back to the originating port by the port index carried in the
// upper tag bits. Zero-length descriptors are never forwarded; they are
// answered locally with error ZLEN_ERR.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   bus      - recon_desc_arb_if master modport (requests, DMA descriptor,
//              DMA completion, routed completion, outstanding counters)
// ---------------------------------------------------------------------------
module recon_desc_arb
   import recon_pkg::*;
#(
   parameter int PORTS              = 2,
   parameter int ADDR_WIDTH         = 34,
   parameter int DMA_DESC_LEN_WIDTH = 20,
   parameter int DMA_DESC_TAG_WIDTH = 8,
   parameter int MAX_OUTSTANDING    = 4
)(
   input logic             clk,
   input logic             rst,
   recon_desc_arb_if.master bus
);
   localparam int CL_PORTS    = clPorts(PORTS);
   localparam int M_TAG_WIDTH = DMA_DESC_TAG_WIDTH + CL_PORTS;
   localparam int CNT_WIDTH   = $clog2(MAX_OUTSTANDING + 1);

   state_t                              r_state;
   state_t                              w_stateNext;
   logic [ADDR_WIDTH-1:0]               r_addr;
   logic [DMA_DESC_LEN_WIDTH-1:0]       r_len;
   logic [DMA_DESC_TAG_WIDTH-1:0]       r_tag;
   logic [CL_PORTS-1:0]                 r_port;
   logic [PORTS-1:0][CNT_WIDTH-1:0]     r_outstanding;
   logic [PORTS-1:0]                    r_stsValid;
   logic [DMA_DESC_TAG_WIDTH-1:0]       r_stsTag;
   logic [3:0]                          r_stsErr;

   logic [PORTS-1:0]                    w_eligible;
   logic [PORTS-1:0]                    w_grant;
   logic [PORTS-1:0]                    w_ready;
   logic [PORTS-1:0]                    w_inc;
   logic [PORTS-1:0]                    w_dec;
   logic [PORTS-1:0]                    w_localOneHot;
   logic [CL_PORTS-1:0]                 w_grantIdx;
   logic [CL_PORTS-1:0]                 w_stsPort;
   logic [DMA_DESC_LEN_WIDTH-1:0]       w_selLen;
   logic                                w_anyGrant;
   logic                                w_accept;
   logic                                w_issueAccept;
   logic                                w_localSts;
   logic                                w_mValid;
   logic                                w_stsPortOk;

   // A port may compete only while it has room for another in-flight
   // descriptor; a full port simply sees ready stay low.
   always_comb begin
      w_eligible = '0;
      for (int p = 0; p < PORTS; p++) begin
         w_eligible[p] = bus.s_axis_desc_valid[p] &&
                         (r_outstanding[p] < CNT_WIDTH'(MAX_OUTSTANDING));
      end
   end

   assign w_accept = (r_state == ST_IDLE) && w_anyGrant && !rst;
   assign w_selLen = bus.s_axis_desc_len[int'(w_grantIdx)*DMA_DESC_LEN_WIDTH +: DMA_DESC_LEN_WIDTH];

   recon_rr_arb #(
      .PORTS    (PORTS),
      .CL_PORTS (CL_PORTS)
   ) u_rrArb (
      .clk        (clk),
      .rst        (rst),
      .i_req      (w_eligible),
      .i_accept   (w_accept),
      .o_grant    (w_grant),
      .o_grantIdx (w_grantIdx),
      .o_anyGrant (w_anyGrant)
   );

   // Next-state and handshake decode. Ready is raised only from IDLE, so at
   // most one descriptor is ever held. The local zero-length response waits
   // for a cycle with no DMA completion, because DMA status owns the shared
   // completion registers whenever it is present.
   always_comb begin
      w_stateNext   = r_state;
      w_ready       = '0;
      w_mValid      = 1'b0;
      w_issueAccept = 1'b0;
      w_localSts    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ready = w_grant;
            if (w_anyGrant) begin
               w_stateNext = (w_selLen != '0) ? ST_ISSUE : ST_ZLEN_RESP;
            end
         end
         ST_ISSUE: begin
            w_mValid      = 1'b1;
            w_issueAccept = bus.m_axis_desc_ready;
            if (bus.m_axis_desc_ready) begin
               w_stateNext = ST_IDLE;
            end
         end
         ST_ZLEN_RESP: begin
            if (!bus.s_axis_desc_status_valid) begin
               w_localSts  = 1'b1;
               w_stateNext = ST_IDLE;
            end
         end
         default: w_stateNext = ST_IDLE;
      endcase
   end

   // State register; reset drops whatever descriptor was in hand.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Capture the winning descriptor on the grant cycle and hold it unchanged
   // until the DMA takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr <= '0;
         r_len  <= '0;
         r_tag  <= '0;
         r_port <= '0;
      end else if (w_accept) begin
         r_addr <= bus.s_axis_desc_addr[int'(w_grantIdx)*ADDR_WIDTH +: ADDR_WIDTH];
         r_len  <= w_selLen;
         r_tag  <= bus.s_axis_desc_tag[int'(w_grantIdx)*DMA_DESC_TAG_WIDTH +: DMA_DESC_TAG_WIDTH];
         r_port <= w_grantIdx;
      end
   end

   // Decode the DMA completion's port field. An index beyond the last port
   // matches nobody, so such a completion is dropped without touching any
   // counter.
   always_comb begin
      w_stsPort     = bus.s_axis_desc_status_tag[M_TAG_WIDTH-1 -: CL_PORTS];
      w_stsPortOk   = int'(w_stsPort) < PORTS;
      w_dec         = '0;
      w_inc         = '0;
      w_localOneHot = '0;
      for (int p = 0; p < PORTS; p++) begin
         w_dec[p]         = bus.s_axis_desc_status_valid && w_stsPortOk && (int'(w_stsPort) == p);
         w_inc[p]         = w_issueAccept && (int'(r_port) == p);
         w_localOneHot[p] = (int'(r_port) == p);
      end
   end

   // Completion output registers. A DMA completion always wins; the local
   // zero-length answer is only loaded on a cycle the DMA leaves free.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stsValid <= '0;
         r_stsTag   <= '0;
         r_stsErr   <= '0;
      end else if (bus.s_axis_desc_status_valid) begin
         r_stsValid <= w_dec;
         r_stsTag   <= bus.s_axis_desc_status_tag[DMA_DESC_TAG_WIDTH-1:0];
         r_stsErr   <= bus.s_axis_desc_status_error;
      end else if (w_localSts) begin
         r_stsValid <= w_localOneHot;
         r_stsTag   <= r_tag;
         r_stsErr   <= ZLEN_ERR;
      end else begin
         r_stsValid <= '0;
      end
   end

   // In-flight counters count DMA acceptances, not grants. A simultaneous
   // accept and completion on one port cancel out, and a stray completion at
   // zero leaves the counter at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outstanding <= '0;
      end else begin
         for (int p = 0; p < PORTS; p++) begin
            if (w_inc[p] && !w_dec[p]) begin
               r_outstanding[p] <= r_outstanding[p] + CNT_WIDTH'(1);
            end else if (!w_inc[p] && w_dec[p] && (r_outstanding[p] != '0)) begin
               r_outstanding[p] <= r_outstanding[p] - CNT_WIDTH'(1);
            end
         end
      end
   end

   // Every output is forced to zero while reset is held, including the
   // combinational ready and the registered data fields.
   assign bus.s_axis_desc_ready        = rst ? '0 : w_ready;
   assign bus.m_axis_desc_valid        = !rst && w_mValid;
   assign bus.m_axis_desc_addr         = rst ? '0 : r_addr;
   assign bus.m_axis_desc_len          = rst ? '0 : r_len;
   assign bus.m_axis_desc_tag          = rst ? '0 : {r_port, r_tag};
   assign bus.m_axis_desc_status_valid = rst ? '0 : r_stsValid;
   assign bus.m_axis_desc_status_tag   = rst ? '0 : r_stsTag;
   assign bus.m_axis_desc_status_error = rst ? '0 : r_stsErr;
   assign bus.outstanding              = rst ? '0 : r_outstanding;

endmodule

// File: tb/tb_recon_desc_arb.sv
// ---------------------------------------------------------------------------
// tb_recon_desc_arb
// Cycle-by-cycle vector bench for recon_desc_arb with PORTS=2. Each record
// holds the inputs for one clock cycle and the outputs expected during that
// cycle; the multi-cycle scenarios (filling a port, stalling the DMA,
// resetting mid-issue) are built from loops of such records.
// ---------------------------------------------------------------------------
module tb_recon_desc_arb;
   import recon_pkg::*;

   localparam int          PORTS = 2;
   localparam int          AW    = 34;
   localparam int          LW    = 20;
   localparam int          TW    = 8;
   localparam int          MO    = 4;
   localparam logic [33:0] ADDR0 = 34'h2_0000_1000;
   localparam logic [33:0] ADDR1 = 34'h1_0000_2000;
   localparam logic [19:0] L     = 20'h100;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   recon_desc_arb_if #(
      .PORTS(PORTS), .ADDR_WIDTH(AW), .DMA_DESC_LEN_WIDTH(LW),
      .DMA_DESC_TAG_WIDTH(TW), .MAX_OUTSTANDING(MO)
   ) bus ();

   recon_desc_arb #(
      .PORTS(PORTS), .ADDR_WIDTH(AW), .DMA_DESC_LEN_WIDTH(LW),
      .DMA_DESC_TAG_WIDTH(TW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string       name;
      logic        r;
      logic [1:0]  v;
      logic [19:0] l0, l1;
      logic [7:0]  t0, t1;
      logic        mr, sv;
      logic [8:0]  st;
      logic [3:0]  se;
      logic [1:0]  eR;
      logic        eMV;
      logic [8:0]  eMT;
      logic [19:0] eML;
      logic [1:0]  eSV;
      logic [7:0]  eST;
      logic [3:0]  eSE;
      logic [2:0]  eO0, eO1;
   } vec_t;

   vec_t vecs[$];
   int   passCount  = 0;
   int   checkCount = 0;

   // Build one record: inputs first, then the outputs expected this cycle.
   function automatic vec_t V(input string n, input logic r, input logic [1:0] v,
                              input logic [19:0] l0, input logic [19:0] l1,
                              input logic [7:0] t0, input logic [7:0] t1,
                              input logic mr, input logic sv, input logic [8:0] st,
                              input logic [3:0] se, input logic [1:0] eR,
                              input logic eMV, input logic [8:0] eMT,
                              input logic [19:0] eML, input logic [1:0] eSV,
                              input logic [7:0] eST, input logic [3:0] eSE,
                              input logic [2:0] eO0, input logic [2:0] eO1);
      vec_t x;
      x.name = n; x.r = r; x.v = v; x.l0 = l0; x.l1 = l1; x.t0 = t0; x.t1 = t1;
      x.mr = mr; x.sv = sv; x.st = st; x.se = se;
      x.eR = eR; x.eMV = eMV; x.eMT = eMT; x.eML = eML;
      x.eSV = eSV; x.eST = eST; x.eSE = eSE; x.eO0 = eO0; x.eO1 = eO1;
      return x;
   endfunction

   // Compare one observed value against the bench's expected value.
   task automatic checkOutput(input string n, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
      end
   endtask

   // Drive the record's inputs onto the interface.
   task automatic applyStimulus(input vec_t x);
      rst                          = x.r;
      bus.s_axis_desc_addr         = {ADDR1, ADDR0};
      bus.s_axis_desc_len          = {x.l1, x.l0};
      bus.s_axis_desc_tag          = {x.t1, x.t0};
      bus.s_axis_desc_valid        = x.v;
      bus.m_axis_desc_ready        = x.mr;
      bus.s_axis_desc_status_valid = x.sv;
      bus.s_axis_desc_status_tag   = x.st;
      bus.s_axis_desc_status_error = x.se;
   endtask

   // One cycle: drive on the falling edge, check 1ns later, well clear of the
   // next rising edge.
   task automatic runVec(input vec_t x);
      logic [33:0] expAddr;
      @(negedge clk);
      applyStimulus(x);
      #1;
      checkOutput({x.name, ".ready"},    bus.s_axis_desc_ready,        x.eR);
      checkOutput({x.name, ".mValid"},   bus.m_axis_desc_valid,        x.eMV);
      checkOutput({x.name, ".stsValid"}, bus.m_axis_desc_status_valid, x.eSV);
      checkOutput({x.name, ".out0"},     bus.outstanding[2:0],         x.eO0);
      checkOutput({x.name, ".out1"},     bus.outstanding[5:3],         x.eO1);
      if (x.eMV) begin
         expAddr = x.eMT[8] ? ADDR1 : ADDR0;
         checkOutput({x.name, ".mTag"},  bus.m_axis_desc_tag,  x.eMT);
         checkOutput({x.name, ".mLen"},  bus.m_axis_desc_len,  x.eML);
         checkOutput({x.name, ".mAddr"}, bus.m_axis_desc_addr, expAddr);
      end
      if (x.eSV != 2'b00) begin
         checkOutput({x.name, ".stsTag"}, bus.m_axis_desc_status_tag,   x.eST);
         checkOutput({x.name, ".stsErr"}, bus.m_axis_desc_status_error, x.eSE);
      end
      if (x.r) begin
         checkOutput({x.name, ".rstAddr"},   bus.m_axis_desc_addr,         0);
         checkOutput({x.name, ".rstMTag"},   bus.m_axis_desc_tag,          0);
         checkOutput({x.name, ".rstStsTag"}, bus.m_axis_desc_status_tag,   0);
         checkOutput({x.name, ".rstStsErr"}, bus.m_axis_desc_status_error, 0);
      end
      @(posedge clk);
   endtask

   initial begin
      applyStimulus(V("init",1,2'b00,L,L,8'h11,8'h22,0,0,9'h0,4'h0,
                      2'b00,0,9'h0,20'h0,2'b00,8'h0,4'h0,3'd0,3'd0));
      repeat (2) @(posedge clk);

      // Reset state, then both ports requesting: round robin p0 then p1,
      // followed by DMA completions routed back to each port.
      vecs.push_back(V("reset",        1,2'b00,L,L,8'h11,8'h22,0,0,9'h000,4'h0, 2'b00,0,9'h000,20'h0,2'b00,8'h00,4'h0,3'd0,3'd0));
      vecs.push_back(V("rr_p0",        0,2'b11,L,L,8'h11,8'h22,1,0,9'h000,4'h0, 2'b01,0,9'h000,20'h0,2'b00,8'h00,4'h0,3'd0,3'd0));
      vecs.push_back(V("iss_p0",       0,2'b10,L,L,8'h11,8'h22,1,0,9'h000,4'h0, 2'b00,1,9'h011,L,    2'b00,8'h00,4'h0,3'd0,3'd0));
      vecs.push_back(V("rr_p1",        0,2'b11,L,L,8'h11,8'h22,1,0,9'h000,4'h0, 2'b10,0,9'h000,20'h0,2'b00,8'h00,4'h0,3'd1,3'd0));
      vecs.push_back(V("iss_p1",       0,2'b00,L,L,8'h11,8'h22,1,0,9'h000,4'h0, 2'b00,1,9'h122,L,    2'b00,8'h00,4'h0,3'd1,3'd0));
      vecs.push_back(V("sts_in0",      0,2'b00,L,L,8'h11,8'h22,1,1,9'h011,4'h0, 2'b00,0,9'h000,20'h0,2'b00,8'h00,4'h0,3'd1,3'd1));
      vecs.push_back(V("sts_in1",      0,2'b00,L,L,8'h11,8'h22,1,1,9'h122,4'h3, 2'b00,0,9'h000,20'h0,2'b01,8'h11,4'h0,3'd0,3'd1));
      vecs.push_back(V("sts_out1",     0,2'b00,L,L,8'h11,8'h22,0,0,9'h000,4'h0, 2'b00,0,9'h000,20'h0,2'b10,8'h22,4'h3,3'd0,3'd0));
      // Zero-length request on p1 colliding with a DMA completion for p0.
      vecs.push_back(V("zlen_grant",   0,2'b10,L,20'h0,8'h11,8'h5A,0,0,9'h000,4'h0, 2'b10,0,9'h000,20'h0,2'b00,8'h00,4'h0,3'd0,3'd0));
      vecs.push_back(V("zlen_dma_pri", 0,2'b00,L,20'h0,8'h11,8'h5A,0,1,9'h044,4'h0, 2'b00,0,9'h000,20'h0,2'b00,8'h00,4'h0,3'd0,3'd0));
      vecs.push_back(V("dma_sts_first",0,2'b00,L,20'h0,8'h11,8'h5A,0,0,9'h000,4'h0, 2'b00,0,9'h000,20'h0,2'b01,8'h44,4'h0,3'd0,3'd0));
      vecs.push_back(V("zlen_sts",     0,2'b00,L,20'h0,8'h11,8'h5A,0,0,9'h000,4'h0, 2'b00,0,9'h000,20'h0,2'b10,8'h5A,4'hE,3'd0,3'd0));
      vecs.push_back(V("zlen_done",    0,2'b00,L,20'h0,8'h11,8'h5A,0,0,9'h000,4'h0, 2'b00,0,9'h000,20'h0,2'b00,8'h00,4'h0,3'd0,3'd0));
      // Completion for p0 in the same cycle as a p0 DMA acceptance.
      vecs.push_back(V("p0_grant",     0,2'b01,L,L,8'h11,8'h22,0,0,9'h000,4'h0, 2'b01,0,9'h000,20'h0,2'b00,8'h00,4'h0,3'd0,3'd0));
      vecs.push_back(V("p0_issue",     0,2'b00,L,L,8'h11,8'h22,1,0,9'h000,4'h0, 2'b00,1,9'h011,L,    2'b00,8'h00,4'h0,3'd0,3'd0));
      vecs.push_back(V("p0_regrant",   0,2'b01,L,L,8'h11,8'h22,0,0,9'h000,4'h0, 2'b01,0,9'h000,20'h0,2'b00,8'h00,4'h0,3'd1,3'd0));
      vecs.push_back(V("acc_and_sts",  0,2'b00,L,L,8'h11,8'h22,1,1,9'h033,4'h0, 2'b00,1,9'h011,L,    2'b00,8'h00,4'h0,3'd1,3'd0));
      vecs.push_back(V("same_cycle",   0,2'b00,L,L,8'h11,8'h22,0,0,9'h000,4'h0, 2'b00,0,9'h000,20'h0,2'b01,8'h33,4'h0,3'd1,3'd0));
      vecs.push_back(V("drain_in",     0,2'b00,L,L,8'h11,8'h22,0,1,9'h077,4'h0, 2'b00,0,9'h000,20'h0,2'b00,8'h00,4'h0,3'd1,3'd0));
      vecs.push_back(V("drain_out",    0,2'b00,L,L,8'h11,8'h22,0,0,9'h000,4'h0, 2'b00,0,9'h000,20'h0,2'b01,8'h77,4'h0,3'd0,3'd0));

      // Fill p0 to its limit at one descriptor per two cycles.
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0)
            vecs.push_back(V("q_grant",0,2'b01,20'h40,L,8'h10,8'h22,1,0,9'h000,4'h0, 2'b01,0,9'h000,20'h0, 2'b00,8'h00,4'h0,3'(k/2),3'd0));
         else
            vecs.push_back(V("q_issue",0,2'b01,20'h40,L,8'h10,8'h22,1,0,9'h000,4'h0, 2'b00,1,9'h010,20'h40,2'b00,8'h00,4'h0,3'(k/2),3'd0));
      end
      for (int k = 0; k < 4; k++)
         vecs.push_back(V("q_full",    0,2'b01,20'h40,L,8'h10,8'h22,1,0,9'h000,4'h0, 2'b00,0,9'h000,20'h0, 2'b00,8'h00,4'h0,3'd4,3'd0));
      vecs.push_back(V("q_sts",        0,2'b01,20'h40,L,8'h10,8'h22,1,1,9'h099,4'h0, 2'b00,0,9'h000,20'h0, 2'b00,8'h00,4'h0,3'd4,3'd0));
      vecs.push_back(V("q_regrant",    0,2'b01,20'h40,L,8'h10,8'h22,1,0,9'h000,4'h0, 2'b01,0,9'h000,20'h0, 2'b01,8'h99,4'h0,3'd3,3'd0));
      vecs.push_back(V("q_reissue",    0,2'b00,20'h40,L,8'h10,8'h22,1,0,9'h000,4'h0, 2'b00,1,9'h010,20'h40,2'b00,8'h00,4'h0,3'd3,3'd0));
      for (int k = 0; k < 4; k++)
         vecs.push_back(V("q_drain",   0,2'b00,20'h40,L,8'h10,8'h22,0,1,9'h000,4'h0, 2'b00,0,9'h000,20'h0,
                          (k == 0) ? 2'b00 : 2'b01,8'h00,4'h0,3'(4-k),3'd0));

      // DMA stalls for ten cycles: descriptor fields and counters must hold.
      vecs.push_back(V("stall_grant",  0,2'b10,L,20'h200,8'h11,8'h66,0,0,9'h000,4'h0, 2'b10,0,9'h000,20'h0,  2'b01,8'h00,4'h0,3'd0,3'd0));
      for (int k = 0; k < 10; k++)
         vecs.push_back(V("stall_hold",0,2'b00,L,20'h200,8'h11,8'h66,0,0,9'h000,4'h0, 2'b00,1,9'h166,20'h200,2'b00,8'h00,4'h0,3'd0,3'd0));
      vecs.push_back(V("stall_accept", 0,2'b00,L,20'h200,8'h11,8'h66,1,0,9'h000,4'h0, 2'b00,1,9'h166,20'h200,2'b00,8'h00,4'h0,3'd0,3'd0));
      vecs.push_back(V("stall_done",   0,2'b00,L,20'h200,8'h11,8'h66,0,0,9'h000,4'h0, 2'b00,0,9'h000,20'h0,  2'b00,8'h00,4'h0,3'd0,3'd1));

      // Reset while a descriptor is being issued; arbitration restarts at p0.
      vecs.push_back(V("rst_g0",       0,2'b11,L,L,8'h11,8'h22,0,0,9'h000,4'h0, 2'b01,0,9'h000,20'h0,2'b00,8'h00,4'h0,3'd0,3'd1));
      vecs.push_back(V("rst_iss",      0,2'b11,L,L,8'h11,8'h22,0,0,9'h000,4'h0, 2'b00,1,9'h011,L,    2'b00,8'h00,4'h0,3'd0,3'd1));
      vecs.push_back(V("rst_hit",      1,2'b11,L,L,8'h11,8'h22,0,0,9'h000,4'h0, 2'b00,0,9'h000,20'h0,2'b00,8'h00,4'h0,3'd0,3'd0));
      vecs.push_back(V("rst_after",    0,2'b11,L,L,8'h11,8'h22,0,0,9'h000,4'h0, 2'b01,0,9'h000,20'h0,2'b00,8'h00,4'h0,3'd0,3'd0));
      vecs.push_back(V("rst_iss2",     0,2'b00,L,L,8'h11,8'h22,1,0,9'h000,4'h0, 2'b00,1,9'h011,L,    2'b00,8'h00,4'h0,3'd0,3'd0));
      vecs.push_back(V("rst_end",      0,2'b00,L,L,8'h11,8'h22,0,0,9'h000,4'h0, 2'b00,0,9'h000,20'h0,2'b00,8'h00,4'h0,3'd1,3'd0));

      for (int i = 0; i < vecs.size(); i++) begin
         runVec(vecs[i]);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
